led_pattern_shifter: RTL and testbench

//   Parametrised multi-mode LED pattern shifter: next generation of the 4-LED mirror shifter.

---
 rtl/led_pattern_shifter.sv | 150 +++++++++++++++
 tb/tb_led_pattern_shifter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_shifter.sv
// Multi-mode LED pattern shifter: rotate, bounce, mirror and hold, advanced once per prescaler tick.
// Supports seed load, a bounce direction FSM and a one-cycle end-of-period strobe.
module led_pattern_shifter #(
   parameter int N_LEDS  = 8,
   parameter int NB_MODE = 2
) (
   input  logic               clock,
   input  logic               i_reset_n,
   input  logic               i_valid,
   input  logic [NB_MODE-1:0] i_mode,
   input  logic               i_dir,
   input  logic               i_load,
   input  logic [N_LEDS-1:0]  i_seed,
   output logic [N_LEDS-1:0]  o_led,
   output logic               o_dir,
   output logic               o_wrap
);

   localparam int HALF = N_LEDS / 2;
   localparam int SW   = $clog2(N_LEDS);

   localparam logic [NB_MODE-1:0] MODE_ROTATE = NB_MODE'(0);
   localparam logic [NB_MODE-1:0] MODE_BOUNCE = NB_MODE'(1);
   localparam logic [NB_MODE-1:0] MODE_MIRROR = NB_MODE'(2);

   localparam logic [SW-1:0] ROT_LAST = SW'(N_LEDS - 1);
   localparam logic [SW-1:0] MIR_LAST = SW'(HALF - 1);

   localparam logic [N_LEDS-1:0] LED_ONE    = N_LEDS'(1);
   localparam logic [N_LEDS-1:0] LED_MIRROR = {1'b1, {(N_LEDS-2){1'b0}}, 1'b1};

   generate
      if ((N_LEDS < 4) || ((N_LEDS % 2) != 0)) begin : g_bad_n_leds
         $error("led_pattern_shifter: N_LEDS must be even and >= 4");
      end
      if (NB_MODE < 2) begin : g_bad_nb_mode
         $error("led_pattern_shifter: NB_MODE must be >= 2");
      end
   endgenerate

   typedef enum logic {
      DIR_TO_MSB = 1'b0,
      DIR_TO_LSB = 1'b1
   } bounce_dir_t;

   logic [N_LEDS-1:0]  r_led;
   logic [NB_MODE-1:0] r_mode;
   bounce_dir_t        r_dir;
   logic [SW-1:0]      r_step;
   logic               r_wrap;

   logic [N_LEDS-1:0]  w_led_nxt;
   logic [NB_MODE-1:0] w_mode_nxt;
   bounce_dir_t        w_dir_nxt;
   logic [SW-1:0]      w_step_nxt;
   logic               w_wrap_nxt;

   logic [N_LEDS-1:0]  w_rot_left;
   logic [N_LEDS-1:0]  w_rot_right;
   logic [N_LEDS-1:0]  w_shift_left;
   logic [N_LEDS-1:0]  w_shift_right;
   logic [HALF-1:0]    w_lo;
   logic [HALF-1:0]    w_hi;
   logic [N_LEDS-1:0]  w_mirror_conv;
   logic [N_LEDS-1:0]  w_mirror_div;
   logic [SW-1:0]      w_step_inc;

   assign w_rot_left    = {r_led[N_LEDS-2:0], r_led[N_LEDS-1]};
   assign w_rot_right   = {r_led[0], r_led[N_LEDS-1:1]};
   assign w_shift_left  = {r_led[N_LEDS-2:0], 1'b0};
   assign w_shift_right = {1'b0, r_led[N_LEDS-1:1]};
   assign w_lo          = r_led[HALF-1:0];
   assign w_hi          = r_led[N_LEDS-1:HALF];
   // Each half rotates on its own, so the two dots meet in the middle or at the ends.
   assign w_mirror_conv = {w_hi[0], w_hi[HALF-1:1], w_lo[HALF-2:0], w_lo[HALF-1]};
   assign w_mirror_div  = {w_hi[HALF-2:0], w_hi[HALF-1], w_lo[0], w_lo[HALF-1:1]};
   assign w_step_inc    = r_step + SW'(1);

   always_ff @(posedge clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_led  <= LED_MIRROR;
         r_mode <= MODE_MIRROR;
         r_dir  <= DIR_TO_MSB;
         r_step <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_led  <= w_led_nxt;
         r_mode <= w_mode_nxt;
         r_dir  <= w_dir_nxt;
         r_step <= w_step_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   always_comb begin
      w_led_nxt  = r_led;
      w_mode_nxt = r_mode;
      w_dir_nxt  = r_dir;
      w_step_nxt = r_step;
      w_wrap_nxt = 1'b0;
      if (i_load) begin
         w_led_nxt  = i_seed;
         w_mode_nxt = i_mode;
         w_dir_nxt  = DIR_TO_MSB;
         w_step_nxt = '0;
      end else if (i_valid) begin
         if (i_mode != r_mode) begin
            w_mode_nxt = i_mode;
            w_dir_nxt  = DIR_TO_MSB;
            w_step_nxt = '0;
            if ((i_mode == MODE_ROTATE) || (i_mode == MODE_BOUNCE)) begin
               w_led_nxt = LED_ONE;
            end else if (i_mode == MODE_MIRROR) begin
               w_led_nxt = LED_MIRROR;
            end
         end else if (r_mode == MODE_ROTATE) begin
            w_led_nxt  = i_dir ? w_rot_right : w_rot_left;
            w_wrap_nxt = (r_step == ROT_LAST);
            w_step_nxt = (r_step == ROT_LAST) ? '0 : w_step_inc;
         end else if (r_mode == MODE_MIRROR) begin
            w_led_nxt  = i_dir ? w_mirror_div : w_mirror_conv;
            w_wrap_nxt = (r_step == MIR_LAST);
            w_step_nxt = (r_step == MIR_LAST) ? '0 : w_step_inc;
         end else if (r_mode == MODE_BOUNCE) begin
            // Reversal at the LSB end closes one bounce period.
            if (r_dir == DIR_TO_MSB) begin
               if (r_led[N_LEDS-1]) begin
                  w_dir_nxt = DIR_TO_LSB;
                  w_led_nxt = w_shift_right;
               end else begin
                  w_led_nxt = w_shift_left;
               end
            end else begin
               if (r_led[0]) begin
                  w_dir_nxt  = DIR_TO_MSB;
                  w_led_nxt  = w_shift_left;
                  w_wrap_nxt = 1'b1;
               end else begin
                  w_led_nxt = w_shift_right;
               end
            end
         end
      end
   end

   assign o_led  = r_led;
   assign o_dir  = r_dir;
   assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed, table-driven bench for led_pattern_shifter at N_LEDS=8.
// Vector table covers mode sequences; async reset and idle hold are hand-written sequences.
module tb_led_pattern_shifter;

   localparam logic [1:0] ROT = 2'b00;
   localparam logic [1:0] BNC = 2'b01;
   localparam logic [1:0] MIR = 2'b10;
   localparam logic [1:0] HLD = 2'b11;

   logic       clock;
   logic       i_reset_n;
   logic       i_valid;
   logic [1:0] i_mode;
   logic       i_dir;
   logic       i_load;
   logic [7:0] i_seed;
   logic [7:0] o_led;
   logic       o_dir;
   logic       o_wrap;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      name;
      logic       valid;
      logic       load;
      logic [1:0] mode;
      logic       dir;
      logic [7:0] seed;
      logic [7:0] expLed;
      logic       expDir;
      logic       expWrap;
   } vec_t;

   vec_t vecs[$];

   led_pattern_shifter #(.N_LEDS(8), .NB_MODE(2)) dut (
      .clock     (clock),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_mode    (i_mode),
      .i_dir     (i_dir),
      .i_load    (i_load),
      .i_seed    (i_seed),
      .o_led     (o_led),
      .o_dir     (o_dir),
      .o_wrap    (o_wrap)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic addVec(input string name, input logic v, input logic l, input logic [1:0] m,
                         input logic d, input logic [7:0] s, input logic [7:0] eLed,
                         input logic eDir, input logic eWrap);
      vec_t t;
      t.name    = name;
      t.valid   = v;
      t.load    = l;
      t.mode    = m;
      t.dir     = d;
      t.seed    = s;
      t.expLed  = eLed;
      t.expDir  = eDir;
      t.expWrap = eWrap;
      vecs.push_back(t);
   endtask

   // Drive one cycle of inputs, then sample just after the rising edge.
   task automatic applyStimulus(input logic v, input logic l, input logic [1:0] m,
                                input logic d, input logic [7:0] s);
      i_valid = v;
      i_load  = l;
      i_mode  = m;
      i_dir   = d;
      i_seed  = s;
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] eLed,
                              input logic eDir, input logic eWrap);
      checks++;
      if (o_led !== eLed) begin
         errors++;
         $display("[TB] FAIL %s led: got %b want %b", name, o_led, eLed);
      end
      checks++;
      if (o_dir !== eDir) begin
         errors++;
         $display("[TB] FAIL %s dir: got %b want %b", name, o_dir, eDir);
      end
      checks++;
      if (o_wrap !== eWrap) begin
         errors++;
         $display("[TB] FAIL %s wrap: got %b want %b", name, o_wrap, eWrap);
      end
   endtask

   initial begin
      logic [7:0] rotSeq [8];
      logic [7:0] bncUp [7];
      logic [7:0] bncDown [6];

      rotSeq  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      bncUp   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      bncDown = '{8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

      // Mirror from reset: converge period, then a direction change mid-period.
      addVec("mir_c1", 1, 0, MIR, 0, 8'h00, 8'h42, 0, 0);
      addVec("mir_c2", 1, 0, MIR, 0, 8'h00, 8'h24, 0, 0);
      addVec("mir_c3", 1, 0, MIR, 0, 8'h00, 8'h18, 0, 0);
      addVec("mir_c4", 1, 0, MIR, 0, 8'h00, 8'h81, 0, 1);
      addVec("mir_d1", 1, 0, MIR, 1, 8'h00, 8'h18, 0, 0);
      addVec("mir_c5", 1, 0, MIR, 0, 8'h00, 8'h81, 0, 0);
      addVec("mir_c6", 1, 0, MIR, 0, 8'h00, 8'h42, 0, 0);
      addVec("mir_c7", 1, 0, MIR, 0, 8'h00, 8'h24, 0, 1);
      addVec("idle_a", 0, 0, MIR, 0, 8'h00, 8'h24, 0, 0);
      // Rotate: switch, full left period, then reverse.
      addVec("rot_sw", 1, 0, ROT, 0, 8'h00, 8'h01, 0, 0);
      for (int i = 0; i < 8; i++)
         addVec($sformatf("rot_l%0d", i + 1), 1, 0, ROT, 0, 8'h00, rotSeq[i], 0, (i == 7));
      addVec("rot_r1", 1, 0, ROT, 1, 8'h00, 8'h80, 0, 0);
      addVec("rot_r2", 1, 0, ROT, 1, 8'h00, 8'h40, 0, 0);
      addVec("rot_r3", 1, 0, ROT, 1, 8'h00, 8'h20, 0, 0);
      // Bounce: i_dir toggled to show it is ignored.
      addVec("bnc_sw", 1, 0, BNC, 0, 8'h00, 8'h01, 0, 0);
      for (int i = 0; i < 7; i++)
         addVec($sformatf("bnc_u%0d", i + 1), 1, 0, BNC, i[0], 8'h00, bncUp[i], 0, 0);
      addVec("bnc_rev", 1, 0, BNC, 0, 8'h00, 8'h40, 1, 0);
      for (int i = 0; i < 6; i++)
         addVec($sformatf("bnc_d%0d", i + 1), 1, 0, BNC, i[0], 8'h00, bncDown[i], 1, 0);
      addVec("bnc_wrap", 1, 0, BNC, 1, 8'h00, 8'h02, 0, 1);
      addVec("bnc_next", 1, 0, BNC, 0, 8'h00, 8'h04, 0, 0);
      // Load beats a concurrent tick; multi-bit bounce drops bits at the ends.
      addVec("ld_a5",  1, 1, BNC, 0, 8'hA5, 8'hA5, 0, 0);
      addVec("bnc_m1", 1, 0, BNC, 0, 8'h00, 8'h52, 1, 0);
      addVec("bnc_m2", 1, 0, BNC, 0, 8'h00, 8'h29, 1, 0);
      addVec("bnc_m3", 1, 0, BNC, 0, 8'h00, 8'h52, 0, 1);
      addVec("bnc_m4", 1, 0, BNC, 0, 8'h00, 8'hA4, 0, 0);
      addVec("bnc_m5", 1, 0, BNC, 0, 8'h00, 8'h52, 1, 0);
      // Hold: switch keeps the pattern but clears direction.
      addVec("hld_sw", 1, 0, HLD, 0, 8'h00, 8'h52, 0, 0);
      addVec("hld_1",  1, 0, HLD, 1, 8'h00, 8'h52, 0, 0);
      addVec("ld_hld", 1, 1, HLD, 0, 8'hA5, 8'hA5, 0, 0);
      addVec("hld_2",  1, 0, HLD, 0, 8'h00, 8'hA5, 0, 0);
      addVec("hld_3",  1, 0, HLD, 1, 8'h00, 8'hA5, 0, 0);
      // All-zero pattern stays zero.
      addVec("ld_zb",  1, 1, BNC, 0, 8'h00, 8'h00, 0, 0);
      for (int i = 0; i < 16; i++)
         addVec($sformatf("zb_%0d", i + 1), 1, 0, BNC, 0, 8'h00, 8'h00, 0, 0);
      addVec("ld_zr",  0, 1, ROT, 0, 8'h00, 8'h00, 0, 0);
      addVec("zr_1",   1, 0, ROT, 1, 8'h00, 8'h00, 0, 0);
      addVec("zr_2",   1, 0, ROT, 0, 8'h00, 8'h00, 0, 0);
      addVec("mir_sw", 1, 0, MIR, 0, 8'h00, 8'h81, 0, 0);

      i_valid   = 1'b0;
      i_load    = 1'b0;
      i_mode    = MIR;
      i_dir     = 1'b0;
      i_seed    = 8'h00;
      i_reset_n = 1'b1;
      #2 i_reset_n = 1'b0;
      #1;
      checkOutput("reset_async", 8'h81, 0, 0);
      @(posedge clock);
      #1 i_reset_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].valid, vecs[i].load, vecs[i].mode, vecs[i].dir, vecs[i].seed);
         checkOutput(vecs[i].name, vecs[i].expLed, vecs[i].expDir, vecs[i].expWrap);
      end

      // No tick and no load: nothing moves whatever the mode input says.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 2'(i), i[0], 8'hFF);
         checkOutput($sformatf("idle_%0d", i), 8'h81, 0, 0);
      end

      // Asynchronous reset mid-rotate, between clock edges.
      applyStimulus(1, 1, ROT, 0, 8'h10);
      checkOutput("ld_rot10", 8'h10, 0, 0);
      #3 i_reset_n = 1'b0;
      #1;
      checkOutput("reset_mid", 8'h81, 0, 0);
      #2 i_reset_n = 1'b1;
      applyStimulus(1, 0, ROT, 0, 8'h00);
      checkOutput("post_rst_sw", 8'h01, 0, 0);
      applyStimulus(1, 0, ROT, 0, 8'h00);
      checkOutput("post_rst_r1", 8'h02, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
